// File: rtl/regbank_multiport.sv
// regbank_multiport: parametrised multi-port register bank.
//
// Purpose:
//   DEPTH x DATA_WIDTH register bank with READ_PORTS combinational read
//   ports and two write ports. Port 1 wins when both ports write the same
//   address. A hardware clear sequencer zeroes every register after reset
//   or on request. Bereit goes high once the bank is clean.
//   Register 0 always reads as zero.
//
// Ports:
//   Clock, Reset         rising-edge clock, synchronous active-high reset
//   QuellRegister        packed read addresses, port k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   QuellDaten           packed read data, port k at [k*DATA_WIDTH +: DATA_WIDTH]
//   ZielRegister0/1      write addresses
//   ZielDaten0/1         write data
//   Schreibsignal0/1     write enables
//   Loeschen             request a full clear while running
//   Bereit               bank cleared and accepting writes (registered)

// One read port: selects the stored value and optionally forwards same-cycle
// write data. Zero is forced while clearing and for address 0.
module regbank_readport #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int BYPASS     = 1
) (
  input  logic [ADDR_WIDTH-1:0]                     readAddr,
  input  logic [2**ADDR_WIDTH-1:0][DATA_WIDTH-1:0]  regs,
  input  logic                                      inRun,
  input  logic                                      bypassOk,
  input  logic [1:0]                                wrEn,
  input  logic [1:0][ADDR_WIDTH-1:0]                wrAddr,
  input  logic [1:0][DATA_WIDTH-1:0]                wrData,
  output logic [DATA_WIDTH-1:0]                     readData
);

  always_comb begin
    readData = regs[readAddr];
    if (BYPASS != 0 && bypassOk) begin
      if (wrEn[0] && wrAddr[0] == readAddr) readData = wrData[0];
      // Port 1 is checked last so that it overrides port 0, matching the
      // commit priority.
      if (wrEn[1] && wrAddr[1] == readAddr) readData = wrData[1];
    end
    // The zero override also kills any bypass aimed at address 0.
    if (!inRun || readAddr == '0) readData = '0;
  end

endmodule

module regbank_multiport #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int READ_PORTS = 2,
  parameter int BYPASS     = 1
) (
  input  logic                             Clock,
  input  logic                             Reset,
  input  logic [READ_PORTS*ADDR_WIDTH-1:0] QuellRegister,
  output logic [READ_PORTS*DATA_WIDTH-1:0] QuellDaten,
  input  logic [ADDR_WIDTH-1:0]            ZielRegister0,
  input  logic [DATA_WIDTH-1:0]            ZielDaten0,
  input  logic                             Schreibsignal0,
  input  logic [ADDR_WIDTH-1:0]            ZielRegister1,
  input  logic [DATA_WIDTH-1:0]            ZielDaten1,
  input  logic                             Schreibsignal1,
  input  logic                             Loeschen,
  output logic                             Bereit
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  typedef enum logic {CLEAR, RUN} state_t;

  typedef struct packed {
    logic                  en;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } wrReq_t;

  state_t                                state;
  logic [ADDR_WIDTH-1:0]                 cnt;
  logic [DEPTH-1:0][DATA_WIDTH-1:0]      regs;

  wrReq_t [1:0]                          wr;
  logic   [1:0]                          wrEn;
  logic   [1:0]                          wrCommit;
  logic   [1:0][ADDR_WIDTH-1:0]          wrAddr;
  logic   [1:0][DATA_WIDTH-1:0]          wrData;

  logic [READ_PORTS-1:0][ADDR_WIDTH-1:0] rdAddr;
  logic [READ_PORTS-1:0][DATA_WIDTH-1:0] rdData;

  logic inRun;
  logic bypassOk;

  assign wr[0] = '{en: Schreibsignal0, addr: ZielRegister0, data: ZielDaten0};
  assign wr[1] = '{en: Schreibsignal1, addr: ZielRegister1, data: ZielDaten1};

  genvar p;
  generate
    for (p = 0; p < 2; p++) begin : gWr
      assign wrEn[p]     = wr[p].en;
      assign wrAddr[p]   = wr[p].addr;
      assign wrData[p]   = wr[p].data;
      // Writes to register 0 are dropped so it stays hardwired to zero.
      assign wrCommit[p] = wr[p].en && (wr[p].addr != '0);
    end
  endgenerate

  assign inRun    = (state == RUN);
  // On the edge that enters CLEAR, the writes are discarded. Forwarding is
  // therefore suppressed in that cycle too.
  assign bypassOk = inRun && !Loeschen;

  // Sequencer and storage. Register contents have no reset; the clear
  // sequence defines them before Bereit rises.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state  <= CLEAR;
      cnt    <= '0;
      Bereit <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          regs[cnt] <= '0;
          cnt       <= cnt + 1'b1;
          if (cnt == '1) begin
            state  <= RUN;
            Bereit <= 1'b1;
          end
        end
        RUN: begin
          if (Loeschen) begin
            state  <= CLEAR;
            cnt    <= '0;
            Bereit <= 1'b0;
          end else begin
            if (wrCommit[0]) regs[wr[0].addr] <= wr[0].data;
            // Later assignment wins: port 1 has priority on equal addresses.
            if (wrCommit[1]) regs[wr[1].addr] <= wr[1].data;
          end
        end
        default: begin
          state  <= CLEAR;
          cnt    <= '0;
          Bereit <= 1'b0;
        end
      endcase
    end
  end

  assign rdAddr     = QuellRegister;
  assign QuellDaten = rdData;

  genvar k;
  generate
    for (k = 0; k < READ_PORTS; k++) begin : gRd
      regbank_readport #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .BYPASS    (BYPASS)
      ) uReadPort (
        .readAddr(rdAddr[k]),
        .regs    (regs),
        .inRun   (inRun),
        .bypassOk(bypassOk),
        .wrEn    (wrEn),
        .wrAddr  (wrAddr),
        .wrData  (wrData),
        .readData(rdData[k])
      );
    end
  endgenerate

endmodule

// File: tb/tb_regbank_multiport.sv
// tb_regbank_multiport: directed, table-driven bench for regbank_multiport.
// It drives a BYPASS=1 instance and a BYPASS=0 instance from the same
// stimulus, so forwarding and non-forwarding behaviour are compared
// side by side.
module tb_regbank_multiport;

  logic        Clock;
  logic        Reset;
  logic [5:0]  ra0, ra1;
  logic [11:0] QuellRegister;
  logic [63:0] qB, qN;
  logic [5:0]  ZielRegister0, ZielRegister1;
  logic [31:0] ZielDaten0, ZielDaten1;
  logic        Schreibsignal0, Schreibsignal1;
  logic        Loeschen;
  logic        bereitB, bereitN;

  int checks = 0;
  int errors = 0;

  assign QuellRegister = {ra1, ra0};

  regbank_multiport #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .READ_PORTS(2), .BYPASS(1)) dutB (
    .Clock(Clock), .Reset(Reset), .QuellRegister(QuellRegister), .QuellDaten(qB),
    .ZielRegister0(ZielRegister0), .ZielDaten0(ZielDaten0), .Schreibsignal0(Schreibsignal0),
    .ZielRegister1(ZielRegister1), .ZielDaten1(ZielDaten1), .Schreibsignal1(Schreibsignal1),
    .Loeschen(Loeschen), .Bereit(bereitB));

  regbank_multiport #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .READ_PORTS(2), .BYPASS(0)) dutN (
    .Clock(Clock), .Reset(Reset), .QuellRegister(QuellRegister), .QuellDaten(qN),
    .ZielRegister0(ZielRegister0), .ZielDaten0(ZielDaten0), .Schreibsignal0(Schreibsignal0),
    .ZielRegister1(ZielRegister1), .ZielDaten1(ZielDaten1), .Schreibsignal1(Schreibsignal1),
    .Loeschen(Loeschen), .Bereit(bereitN));

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we0;
    logic [5:0]  a0;
    logic [31:0] d0;
    logic        we1;
    logic [5:0]  a1;
    logic [31:0] d1;
    logic [5:0]  r0;
    logic [5:0]  r1;
    logic [31:0] eb0;   // bypass build, read port 0
    logic [31:0] eb1;
    logic [31:0] en0;   // no-bypass build
    logic [31:0] en1;
  } vec_t;

  vec_t vecs[14];

  initial begin
    // Each vector is applied after an edge and checked before the next one.
    // The write then commits on that next edge.
    vecs[0]  = '{1, 5, 32'hDEADBEEF, 0, 0, 0,            5, 0, 32'hDEADBEEF, 0, 0, 0};
    vecs[1]  = '{0, 0, 0,            0, 0, 0,            5, 0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0};
    vecs[2]  = '{1, 7, 32'h11111111, 1, 7, 32'h22222222, 7, 7, 32'h22222222, 32'h22222222, 0, 0};
    vecs[3]  = '{0, 0, 0,            0, 0, 0,            7, 5, 32'h22222222, 32'hDEADBEEF, 32'h22222222, 32'hDEADBEEF};
    vecs[4]  = '{1, 7, 32'h33333333, 1, 8, 32'h44444444, 7, 8, 32'h33333333, 32'h44444444, 32'h22222222, 0};
    vecs[5]  = '{0, 0, 0,            0, 0, 0,            7, 8, 32'h33333333, 32'h44444444, 32'h33333333, 32'h44444444};
    vecs[6]  = '{1, 3, 32'hCAFEF00D, 0, 0, 0,            3, 3, 32'hCAFEF00D, 32'hCAFEF00D, 0, 0};
    vecs[7]  = '{0, 0, 0,            0, 0, 0,            3, 5, 32'hCAFEF00D, 32'hDEADBEEF, 32'hCAFEF00D, 32'hDEADBEEF};
    vecs[8]  = '{1, 0, 32'hFFFFFFFF, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0};
    vecs[9]  = '{0, 0, 0,            0, 0, 0,            0, 3, 0, 32'hCAFEF00D, 0, 32'hCAFEF00D};
    vecs[10] = '{0, 0, 0,            1, 9, 32'h00001234, 9, 8, 32'h00001234, 32'h44444444, 0, 32'h44444444};
    vecs[11] = '{0, 0, 0,            0, 0, 0,            9, 9, 32'h00001234, 32'h00001234, 32'h00001234, 32'h00001234};
    vecs[12] = '{0, 5, 32'h0BADBAD0, 0, 0, 0,            5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[13] = '{0, 0, 0,            0, 0, 0,            5, 9, 32'hDEADBEEF, 32'h00001234, 32'hDEADBEEF, 32'h00001234};

    Reset = 1'b1; Loeschen = 1'b0;
    Schreibsignal0 = 1'b0; Schreibsignal1 = 1'b0;
    ZielRegister0 = '0; ZielRegister1 = '0; ZielDaten0 = '0; ZielDaten1 = '0;
    ra0 = 6'd5; ra1 = 6'd0;

    // Reset held for two edges.
    repeat (2) @(posedge Clock);
    #1;
    chk("reset_bereitB", {31'b0, bereitB}, 0);
    chk("reset_bereitN", {31'b0, bereitN}, 0);
    chk("reset_readB", qB[31:0], 0);

    // Release reset: Bereit must rise on exactly the 64th edge.
    Reset = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(posedge Clock); #1;
      chk($sformatf("clear_bereitB_e%0d", i + 1), {31'b0, bereitB}, (i == 63) ? 1 : 0);
      chk($sformatf("clear_bereitN_e%0d", i + 1), {31'b0, bereitN}, (i == 63) ? 1 : 0);
    end

    // All 64 registers read zero after the clear.
    for (int a = 0; a < 64; a++) begin
      ra0 = 6'(a); ra1 = 6'(63 - a);
      #1;
      chk($sformatf("cleared_r%0d", a), qB[31:0], 0);
      chk($sformatf("cleared_N_r%0d", 63 - a), qN[63:32], 0);
    end

    // Table-driven RUN vectors.
    for (int v = 0; v < 14; v++) begin
      @(posedge Clock); #1;
      Schreibsignal0 = vecs[v].we0; ZielRegister0 = vecs[v].a0; ZielDaten0 = vecs[v].d0;
      Schreibsignal1 = vecs[v].we1; ZielRegister1 = vecs[v].a1; ZielDaten1 = vecs[v].d1;
      ra0 = vecs[v].r0; ra1 = vecs[v].r1;
      @(negedge Clock);
      chk($sformatf("vec%0d_B_q0", v), qB[31:0],  vecs[v].eb0);
      chk($sformatf("vec%0d_B_q1", v), qB[63:32], vecs[v].eb1);
      chk($sformatf("vec%0d_N_q0", v), qN[31:0],  vecs[v].en0);
      chk($sformatf("vec%0d_N_q1", v), qN[63:32], vecs[v].en1);
    end

    // Clear request with a write on the same edge. The write must be
    // discarded and must not be forwarded.
    @(posedge Clock); #1;
    Loeschen = 1'b1;
    Schreibsignal0 = 1'b1; ZielRegister0 = 6'd10; ZielDaten0 = 32'hAAAA5555;
    Schreibsignal1 = 1'b0;
    ra0 = 6'd10; ra1 = 6'd9;
    @(negedge Clock);
    chk("loeschen_nobypass_r10", qB[31:0], 0);
    chk("loeschen_r9_still", qB[63:32], 32'h00001234);
    chk("loeschen_bereit_still", {31'b0, bereitB}, 1);

    @(posedge Clock); #1;
    Loeschen = 1'b0;
    Schreibsignal0 = 1'b1; ZielRegister0 = 6'd9;  ZielDaten0 = 32'h55555555;
    Schreibsignal1 = 1'b1; ZielRegister1 = 6'd10; ZielDaten1 = 32'h66666666;
    ra0 = 6'd9; ra1 = 6'd10;
    chk("clearing_bereit_low", {31'b0, bereitB}, 0);
    chk("clearing_readB_r9", qB[31:0], 0);
    chk("clearing_readB_r10", qB[63:32], 0);
    chk("clearing_readN_r9", qN[31:0], 0);

    // Clear cycle 20: pulse Reset, which restarts the clear from address 0.
    repeat (19) @(posedge Clock);
    #1;
    chk("midclear_bereit_low", {31'b0, bereitB}, 0);
    Reset = 1'b1;
    @(posedge Clock); #1;
    Reset = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(posedge Clock); #1;
      chk($sformatf("reclear_bereit_e%0d", i + 1), {31'b0, bereitB}, (i == 63) ? 1 : 0);
    end
    Schreibsignal0 = 1'b0; Schreibsignal1 = 1'b0;
    #1;
    chk("after_clear_r9_B", qB[31:0], 0);
    chk("after_clear_r10_B", qB[63:32], 0);
    chk("after_clear_r9_N", qN[31:0], 0);
    chk("after_clear_r10_N", qN[63:32], 0);
    ra0 = 6'd7; ra1 = 6'd3;
    #1;
    chk("after_clear_r7", qB[31:0], 0);
    chk("after_clear_r3", qB[63:32], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
